ysyx_23060025_axi_write_slave: RTL



---
 rtl/ysyx_23060025_axi_write_slave_pkg.sv | 22 ++
 rtl/ysyx_23060025_axi_write_slave_if.sv | 33 +++
 rtl/ysyx_23060025_axi_write_slave_lfsr8.sv | 23 ++
 rtl/ysyx_23060025_axi_write_slave.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/ysyx_23060025_axi_write_slave_pkg.sv
// Shared AXI response codes, beat-size codes and FSM encoding for the
// AXI write slave and its testbench.
package ysyx_23060025_axi_write_slave_pkg;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    localparam logic [2:0] AXI_ADDR_SIZE_1 = 3'd0;
    localparam logic [2:0] AXI_ADDR_SIZE_2 = 3'd1;
    localparam logic [2:0] AXI_ADDR_SIZE_4 = 3'd2;

    localparam logic [3:0] AXI_W_STRB_32   = 4'b1111;
    localparam int         AXI_STRB_W      = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_RESP = 2'd2
    } wslave_state_t;

endpackage

// File: rtl/ysyx_23060025_axi_write_slave_if.sv
// AW/W/B channel bundle between a write master and the write slave.
interface ysyx_23060025_axi_write_slave_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] aw_addr_i;
    logic                  aw_valid_i;
    logic                  aw_ready_o;
    logic [7:0]            aw_len_i;
    logic [2:0]            aw_size_i;
    logic [DATA_WIDTH-1:0] w_data_i;
    logic [3:0]            w_strb_i;
    logic                  w_valid_i;
    logic                  w_ready_o;
    logic                  w_last_i;
    logic                  b_valid_o;
    logic                  b_ready_i;
    logic [1:0]            b_resp_o;

    modport master (
        output aw_addr_i, aw_valid_i, aw_len_i, aw_size_i,
        output w_data_i, w_strb_i, w_valid_i, w_last_i,
        output b_ready_i,
        input  aw_ready_o, w_ready_o, b_valid_o, b_resp_o
    );

    modport slave (
        input  aw_addr_i, aw_valid_i, aw_len_i, aw_size_i,
        input  w_data_i, w_strb_i, w_valid_i, w_last_i,
        input  b_ready_i,
        output aw_ready_o, w_ready_o, b_valid_o, b_resp_o
    );
endinterface

// File: rtl/ysyx_23060025_axi_write_slave_lfsr8.sv
// 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) used to randomise handshake timing.
// Only built when YSYX_23060025_AXI_WSLAVE_RAND_STALL_EN is defined.
`ifdef YSYX_23060025_AXI_WSLAVE_RAND_STALL_EN
module ysyx_23060025_lfsr8 (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic [7:0] seed,
    output logic [7:0] state
);
    logic feedback;

    assign feedback = state[7] ^ state[5] ^ state[4] ^ state[3];

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= seed;
        end else if (enable) begin
            state <= {state[6:0], feedback};
        end
    end
endmodule
`endif

// File: rtl/ysyx_23060025_axi_write_slave.sv
// AXI4-subset write responder (AW/W/B) over a word-addressed array with a
// combinational debug read port. Optional random stalls: YSYX_23060025_AXI_WSLAVE_RAND_STALL_EN.
module ysyx_23060025_axi_write_slave
    import ysyx_23060025_axi_write_slave_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    MEM_DEPTH_W = 10,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 32'h8000_0000
) (
    input  logic                                clock,
    input  logic                                reset,
    ysyx_23060025_axi_write_slave_if.slave      bus,
    input  logic [MEM_DEPTH_W-1:0]              dbg_raddr_i,
    output logic [DATA_WIDTH-1:0]               dbg_rdata_o
);
    localparam int MEM_DEPTH = 1 << MEM_DEPTH_W;

    wslave_state_t         state_q, state_d;
    logic [ADDR_WIDTH-1:0] cur_addr_q;
    logic [7:0]            len_q;
    logic [7:0]            beat_cnt_q;
    logic [2:0]            size_q;
    logic [1:0]            err_q;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    logic                  aw_ready, w_ready, b_valid;
    logic [1:0]            b_resp;
    logic                  aw_fire, w_fire, b_fire;
    logic                  w_gate, b_gate;

    logic [ADDR_WIDTH-1:0] offset;
    logic                  in_range;
    logic [MEM_DEPTH_W-1:0] word_idx;
    logic                  beat_is_len;
    logic                  w_term;
    logic [1:0]            beat_err;

    assign aw_fire = bus.aw_valid_i & aw_ready;
    assign w_fire  = bus.w_valid_i  & w_ready;
    assign b_fire  = b_valid        & bus.b_ready_i;

    // A wrapped address lands below BASE_ADDR and so shows up as a huge offset.
    assign offset      = cur_addr_q - BASE_ADDR;
    assign in_range    = (offset >> (MEM_DEPTH_W + 2)) == '0;
    assign word_idx    = offset[MEM_DEPTH_W+1:2];
    assign beat_is_len = (beat_cnt_q == len_q);
    assign w_term      = bus.w_last_i | beat_is_len;

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        beat_err = err_q;
        if (!in_range) begin
            beat_err = AXI_RESP_DECERR;
        end
        if ((bus.w_last_i != beat_is_len) && (beat_err != AXI_RESP_DECERR)) begin
            beat_err = AXI_RESP_SLVERR;
        end
    end

`ifdef YSYX_23060025_AXI_WSLAVE_RAND_STALL_EN
    logic [7:0] lfsr;
    logic       b_seen_q;

    ysyx_23060025_lfsr8 u_lfsr (
        .clock  (clock),
        .reset  (reset),
        .enable (1'b1),
        .seed   (8'hA5),
        .state  (lfsr)
    );

    // Remembers that LFSR[1] went high during RESP so b_valid holds once raised.
    always_ff @(posedge clock) begin
        if (reset) begin
            b_seen_q <= 1'b0;
        end else if (state_q != ST_RESP || b_fire) begin
            b_seen_q <= 1'b0;
        end else if (lfsr[1]) begin
            b_seen_q <= 1'b1;
        end
    end

    assign w_gate = lfsr[0];
    assign b_gate = b_seen_q | lfsr[1];
`else
    assign w_gate = 1'b1;
    assign b_gate = 1'b1;
`endif

    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (aw_fire)           state_d = ST_DATA;
            ST_DATA: if (w_fire && w_term)  state_d = ST_RESP;
            ST_RESP: if (b_fire)            state_d = ST_IDLE;
            default:                        state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        aw_ready = 1'b0;
        w_ready  = 1'b0;
        b_valid  = 1'b0;
        b_resp   = AXI_RESP_OKAY;
        case (state_q)
            ST_IDLE: aw_ready = 1'b1;
            ST_DATA: w_ready  = w_gate;
            ST_RESP: begin
                b_valid = b_gate;
                b_resp  = err_q;
            end
            default: ;
        endcase
    end

    assign bus.aw_ready_o = aw_ready;
    assign bus.w_ready_o  = w_ready;
    assign bus.b_valid_o  = b_valid;
    assign bus.b_resp_o   = b_resp;

    always_ff @(posedge clock) begin
        if (reset) begin
            cur_addr_q <= '0;
            len_q      <= '0;
            beat_cnt_q <= '0;
            size_q     <= '0;
            err_q      <= AXI_RESP_OKAY;
        end else if (aw_fire) begin
            cur_addr_q <= bus.aw_addr_i;
            len_q      <= bus.aw_len_i;
            size_q     <= bus.aw_size_i;
            beat_cnt_q <= '0;
            err_q      <= (bus.aw_size_i > AXI_ADDR_SIZE_4) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
        end else if (w_fire) begin
            cur_addr_q <= cur_addr_q + (ADDR_WIDTH'(1) << size_q);
            beat_cnt_q <= beat_cnt_q + 8'd1;
            err_q      <= beat_err;
        end
    end

    // NOTE: the array has no reset; contents survive reset and power up undefined.
    always_ff @(posedge clock) begin
        if (w_fire && in_range && (err_q == AXI_RESP_OKAY)) begin
            for (int i = 0; i < AXI_STRB_W; i++) begin
                if (bus.w_strb_i[i]) begin
                    mem[word_idx][8*i +: 8] <= bus.w_data_i[8*i +: 8];
                end
            end
        end
    end

    assign dbg_rdata_o = mem[dbg_raddr_i];

endmodule
